// File: rtl/pwm_cmd_sched.sv
// pwm_cmd_sched: UART byte stream -> per-channel PWM duty registers.
// Frames are HDR_BYTE, CH, DUTY. Shadow duties are copied to the active set
// only on a PWM period boundary, so a running period is never cut short.
// Optional build macro: PWM_CMD_CHECKSUM_EN adds a trailing XOR checksum byte.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// S_IDLE     | waiting for HDR_BYTE, other bytes dropped
// S_GET_CH   | waiting for channel byte
// S_GET_DUTY | waiting for duty byte
// S_GET_CSUM | waiting for checksum byte (PWM_CMD_CHECKSUM_EN only)
// S_COMMIT   | single cycle, writes shadow[ch] and raises pending
module pwm_cmd_sched #(
    parameter int         NUM_CH       = 4,
    parameter logic [7:0] HDR_BYTE     = 8'hA5,
    parameter int         TIMEOUT_CLKS = 21700
) (
    input  logic                  i_Clock,
    input  logic                  i_Rst_n,
    input  logic                  i_RX_DV,
    input  logic [7:0]            i_RX_Data,
    input  logic                  i_Period_Start,
    output logic [NUM_CH*8-1:0]   o_Duty,
    output logic                  o_Update,
    output logic                  o_Busy,
    output logic                  o_Err
);

    localparam int            TW       = $clog2(TIMEOUT_CLKS + 1);
    localparam logic [TW-1:0] TMO_LOAD = TW'(TIMEOUT_CLKS - 1);
    localparam logic [4:0]    NUM_CH_W = 5'(NUM_CH);

    typedef enum logic [2:0] {
        S_IDLE,
        S_GET_CH,
        S_GET_DUTY,
        S_COMMIT
`ifdef PWM_CMD_CHECKSUM_EN
        , S_GET_CSUM
`endif
    } state_t;

    state_t          state_q, state_nxt;
    logic [3:0]      ch_q;
    logic [7:0]      duty_q;
    logic [TW-1:0]   cnt_q;
    logic [7:0]      shadow_q [NUM_CH];
    logic [7:0]      active_q [NUM_CH];
    logic            pending_q;
    logic            update_q;
    logic            err_q;

    logic            err_nxt;
    logic            cnt_load;
    logic            cnt_run;
    logic            ch_we;
    logic            duty_we;
    logic            commit;
    logic            bad_ch;
    logic            tmo;

    assign bad_ch = (i_RX_Data[7:4] != 4'd0) || ({1'b0, i_RX_Data[3:0]} >= NUM_CH_W);
    assign tmo    = (cnt_q == '0);

    // State register plus the byte latches it controls.
    always_ff @(posedge i_Clock or negedge i_Rst_n) begin
        if (!i_Rst_n) begin
            state_q <= S_IDLE;
            ch_q    <= '0;
            duty_q  <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_nxt;
            err_q   <= err_nxt;
            if (ch_we)   ch_q   <= i_RX_Data[3:0];
            if (duty_we) duty_q <= i_RX_Data;
        end
    end

    // Inter-byte timeout: down-counter reloaded on each accepted byte, expires at zero.
    always_ff @(posedge i_Clock or negedge i_Rst_n) begin
        if (!i_Rst_n) begin
            cnt_q <= TMO_LOAD;
        end else if (cnt_load) begin
            cnt_q <= TMO_LOAD;
        end else if (cnt_run && !tmo) begin
            cnt_q <= cnt_q - 1'b1;
        end
    end

    // Frame parser: next state, error pulse and latch enables.
    always_comb begin
        state_nxt = state_q;
        err_nxt   = 1'b0;
        cnt_load  = 1'b0;
        cnt_run   = 1'b0;
        ch_we     = 1'b0;
        duty_we   = 1'b0;
        commit    = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (i_RX_DV && (i_RX_Data == HDR_BYTE)) begin
                    state_nxt = S_GET_CH;
                    cnt_load  = 1'b1;
                end
            end
            S_GET_CH: begin
                cnt_run = 1'b1;
                if (i_RX_DV) begin
                    if (bad_ch) begin
                        err_nxt   = 1'b1;
                        state_nxt = S_IDLE;
                    end else begin
                        ch_we     = 1'b1;
                        cnt_load  = 1'b1;
                        state_nxt = S_GET_DUTY;
                    end
                end else if (tmo) begin
                    err_nxt   = 1'b1;
                    state_nxt = S_IDLE;
                end
            end
            S_GET_DUTY: begin
                cnt_run = 1'b1;
                if (i_RX_DV) begin
                    duty_we  = 1'b1;
                    cnt_load = 1'b1;
`ifdef PWM_CMD_CHECKSUM_EN
                    state_nxt = S_GET_CSUM;
`else
                    state_nxt = S_COMMIT;
`endif
                end else if (tmo) begin
                    err_nxt   = 1'b1;
                    state_nxt = S_IDLE;
                end
            end
`ifdef PWM_CMD_CHECKSUM_EN
            S_GET_CSUM: begin
                cnt_run = 1'b1;
                if (i_RX_DV) begin
                    cnt_load = 1'b1;
                    if (i_RX_Data == (HDR_BYTE ^ {4'd0, ch_q} ^ duty_q)) begin
                        state_nxt = S_COMMIT;
                    end else begin
                        err_nxt   = 1'b1;
                        state_nxt = S_IDLE;
                    end
                end else if (tmo) begin
                    err_nxt   = 1'b1;
                    state_nxt = S_IDLE;
                end
            end
`endif
            S_COMMIT: begin
                commit    = 1'b1;
                state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // Shadow/active duty bank; commit wins over transfer for the pending flag.
    always_ff @(posedge i_Clock or negedge i_Rst_n) begin
        if (!i_Rst_n) begin
            for (int i = 0; i < NUM_CH; i++) begin
                shadow_q[i] <= '0;
                active_q[i] <= '0;
            end
            pending_q <= 1'b0;
            update_q  <= 1'b0;
        end else begin
            update_q <= 1'b0;
            if (i_Period_Start && pending_q) begin
                for (int i = 0; i < NUM_CH; i++) begin
                    active_q[i] <= shadow_q[i];
                end
                pending_q <= 1'b0;
                update_q  <= 1'b1;
            end
            if (commit) begin
                for (int i = 0; i < NUM_CH; i++) begin
                    if (ch_q == 4'(i)) shadow_q[i] <= duty_q;
                end
                pending_q <= 1'b1;
            end
        end
    end

    // Pack the active registers onto the flat duty bus.
    always_comb begin
        o_Duty = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            o_Duty[8*i +: 8] = active_q[i];
        end
    end

    assign o_Update = update_q;
    assign o_Err    = err_q;
    assign o_Busy   = (state_q != S_IDLE);

endmodule
